// File: rtl/tbu.sv
// Viterbi traceback unit (K=3, 4 states): walks the decision memory from newest to oldest
// entry starting at the minimum-metric state and emits one decoded bit per traceback.
module tbu #(
    parameter int unsigned TBL      = 15,
    parameter int unsigned PM_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [PM_WIDTH-1:0]     pm_current_s0_i,
    input  logic [PM_WIDTH-1:0]     pm_current_s1_i,
    input  logic [PM_WIDTH-1:0]     pm_current_s2_i,
    input  logic [PM_WIDTH-1:0]     pm_current_s3_i,
    input  logic [3:0]              read_data_i,
    output logic [$clog2(TBL)-1:0]  read_addr_o,
    output logic                    bit_o,
    output logic                    bit_valid_o,
    output logic                    busy_o,
    output logic                    overrun_o
);

    localparam int unsigned AW = $clog2(TBL);
    localparam int unsigned FW = $clog2(TBL + 1);

    typedef enum logic {StIdle, StTrace} state_e;

    state_e                 state_q;
    logic [FW-1:0]          fill_q;
    logic [FW-1:0]          fill_next;
    logic [AW-1:0]          ptr_q;
    logic [AW:0]            ptr_next;
    logic [1:0]             state_reg_q;
    logic                   pending_q;
    logic                   first_q;
    logic                   bit_q;
    logic                   bit_valid_q;
    logic                   overrun_q;
    logic [1:0]             s_min;
    logic [PM_WIDTH-1:0]    pm_min;
    logic [1:0]             s_cur;
    logic                   last_step;

    always_comb begin
        if (fill_q == FW'(TBL)) begin
            fill_next = fill_q;
        end else begin
            fill_next = fill_q + FW'(valid_i);
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        s_min  = 2'd0;
        pm_min = pm_current_s0_i;
        if (pm_current_s1_i < pm_min) begin
            s_min  = 2'd1;
            pm_min = pm_current_s1_i;
        end
        if (pm_current_s2_i < pm_min) begin
            s_min  = 2'd2;
            pm_min = pm_current_s2_i;
        end
        if (pm_current_s3_i < pm_min) begin
            s_min  = 2'd3;
        end
    end

    assign s_cur = first_q ? s_min : state_reg_q;

    // A write during the walk shifts every entry down, so the pointer skips one extra slot.
    // The guard bit goes negative exactly when no unread entry remains.
    assign ptr_next  = {1'b0, ptr_q} - (AW+1)'(1) - (AW+1)'(valid_i);
    assign last_step = ptr_next[AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            fill_q      <= '0;
            ptr_q       <= '0;
            state_reg_q <= 2'd0;
            pending_q   <= 1'b0;
            first_q     <= 1'b0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            fill_q      <= fill_next;
            bit_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if ((valid_i || pending_q) && fill_next == FW'(TBL)) begin
                        state_q   <= StTrace;
                        ptr_q     <= AW'(TBL - 1);
                        first_q   <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                StTrace: begin
                    state_reg_q <= {s_cur[0], read_data_i[s_cur]};
                    first_q     <= 1'b0;
                    ptr_q       <= ptr_next[AW-1:0];
                    if (valid_i) begin
                        pending_q <= 1'b1;
                        if (pending_q) begin
                            overrun_q <= 1'b1;
                        end
                    end
                    if (last_step) begin
                        bit_q       <= s_cur[1];
                        bit_valid_q <= 1'b1;
                        state_q     <= StIdle;
                        // Oldest entry is shifted out before it could be read.
                        if (ptr_q == AW'(1) && valid_i) begin
                            overrun_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o      = (state_q == StTrace);
    assign read_addr_o = busy_o ? ptr_q : '0;
    assign bit_o       = bit_q;
    assign bit_valid_o = bit_valid_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_tbu.sv
// Bench for tbu: models the decision memory, predicts decoded bits into a scoreboard
// and checks addresses, strobes and the overrun flag per scenario.
module tb_tbu;

    localparam int TBL = 15;
    localparam int PMW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           valid_i = 1'b0;
    logic [PMW-1:0] pm [4];
    logic [3:0]     din = 4'h0;
    logic [3:0]     mem [TBL];
    logic [3:0]     read_data_i;
    logic [3:0]     read_addr_o;
    logic           bit_o;
    logic           bit_valid_o;
    logic           busy_o;
    logic           overrun_o;

    int   n_cmp = 0;
    int   n_err = 0;
    logic sb [$];
    logic prev_bv = 1'b0;
    logic exp_bit;

    tbu #(.TBL(TBL), .PM_WIDTH(PMW)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_i         (valid_i),
        .pm_current_s0_i (pm[0]),
        .pm_current_s1_i (pm[1]),
        .pm_current_s2_i (pm[2]),
        .pm_current_s3_i (pm[3]),
        .read_data_i     (read_data_i),
        .read_addr_o     (read_addr_o),
        .bit_o           (bit_o),
        .bit_valid_o     (bit_valid_o),
        .busy_o          (busy_o),
        .overrun_o       (overrun_o)
    );

    always #5 clk = ~clk;

    // Decision memory model: shift on every write, newest entry at TBL-1.
    always @(posedge clk) begin
        if (valid_i) begin
            for (int i = 0; i < TBL - 1; i++) mem[i] <= mem[i+1];
            mem[TBL-1] <= din;
        end
    end

    assign read_data_i = (int'(read_addr_o) < TBL) ? mem[read_addr_o] : 4'h0;

    // Scoreboard consumer: every strobe must match the oldest queued prediction.
    always @(negedge clk) begin
        if (bit_valid_o) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_bit: bit_valid_o=1 bit_o=%0b, no bit expected", bit_o);
            end else begin
                exp_bit = sb.pop_front();
                if (bit_o !== exp_bit) begin
                    n_err++;
                    $display("FAIL decoded_bit: got %0b expected %0b", bit_o, exp_bit);
                end
            end
            if (prev_bv) begin
                n_cmp++;
                n_err++;
                $display("FAIL strobe_width: bit_valid_o=1 in two consecutive cycles, expected 0");
            end
        end
        prev_bv = bit_valid_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] d);
        din     = d;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        valid_i = 1'b0;
        sb.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_pm(input int a, input int b, input int c, input int d);
        pm[0] = PMW'(a);
        pm[1] = PMW'(b);
        pm[2] = PMW'(c);
        pm[3] = PMW'(d);
    endtask

    task automatic fill_const(input logic [3:0] d);
        for (int i = 0; i < TBL; i++) pulse(d);
    endtask

    task automatic wait_done();
        logic done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            step();
            if (sb.size() == 0 && !busy_o) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done: traceback still pending after 80 cycles, %0d bits outstanding",
                     sb.size());
            sb.delete();
        end
    endtask

    // Reference traceback over a static memory snapshot.
    function automatic logic model_bit();
        logic [1:0] s = 2'd0;
        logic       b = 1'b0;
        logic [3:0] d;
        for (int i = 1; i < 4; i++) if (pm[i] < pm[s]) s = 2'(i);
        for (int a = TBL - 1; a >= 0; a--) begin
            b = s[1];
            d = mem[a];
            s = {s[0], d[s]};
        end
        return b;
    endfunction

    task automatic test_reset();
        logic bad = 1'b0;
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (read_addr_o !== 4'd0) begin n_err++; $display("FAIL rst_addr: got %0d expected 0", read_addr_o); end
        n_cmp++; if (bit_o !== 1'b0) begin n_err++; $display("FAIL rst_bit: got %0b expected 0", bit_o); end
        n_cmp++; if (bit_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_bit_valid: got %0b expected 0", bit_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b expected 0", busy_o); end
        n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %0b expected 0", overrun_o); end
        rst = 1'b0;
        // Abort a traceback mid-walk.
        set_pm(0, 5, 5, 5);
        fill_const(4'h0);
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %0b expected 1", busy_o); end
        repeat (5) step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++; if (busy_o !== 1'b0 || read_addr_o !== 4'd0 || overrun_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst_outputs: busy=%0b addr=%0d overrun=%0b expected 0/0/0",
                     busy_o, read_addr_o, overrun_o);
        end
        repeat (20) begin
            step();
            if (busy_o || bit_valid_o) bad = 1'b1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL mid_rst_quiet: activity=%0b expected 0", bad); end
    endtask

    task automatic test_fill();
        logic bad = 1'b0;
        do_reset();
        set_pm(0, 5, 5, 5);
        repeat (TBL - 1) pulse(4'h0);
        repeat (3) begin
            if (busy_o) bad = 1'b1;
            step();
        end
        n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL fill_early: busy seen=%0b expected 0", bad); end
        pulse(4'h0);
        sb.push_back(1'b0);
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL fill_start: busy got %0b expected 1", busy_o); end
        for (int i = TBL - 1; i >= 0; i--) begin
            n_cmp++;
            if (read_addr_o !== 4'(i) || busy_o !== 1'b1) begin
                n_err++;
                $display("FAIL fill_addr: addr=%0d busy=%0b expected addr=%0d busy=1",
                         read_addr_o, busy_o, i);
            end
            step();
        end
        n_cmp++; if (bit_valid_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL fill_done: bit_valid=%0b busy=%0b expected 1/0", bit_valid_o, busy_o);
        end
        step();
        n_cmp++; if (bit_valid_o !== 1'b0) begin n_err++; $display("FAIL fill_pulse: bit_valid got %0b expected 0", bit_valid_o); end
    endtask

    task automatic test_paths();
        do_reset(); set_pm(9, 9, 9, 2);       fill_const(4'hF);    sb.push_back(1'b1); wait_done();
        do_reset(); set_pm(7, 7, 7, 7);       fill_const(4'h0);    sb.push_back(1'b0); wait_done();
        // Decisions 1100 make the path alternate s <-> swap(s), so the bit reveals the start state.
        do_reset(); set_pm(7, 7, 7, 7);       fill_const(4'b1100); sb.push_back(1'b0); wait_done();
        do_reset(); set_pm(9, 4, 4, 9);       fill_const(4'b1100); sb.push_back(1'b0); wait_done();
        do_reset(); set_pm(9, 9, 3, 9);       fill_const(4'b1100); sb.push_back(1'b1); wait_done();
        do_reset(); set_pm(100, 250, 150, 200); fill_const(4'b1100); sb.push_back(1'b0); wait_done();
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            do_reset();
            set_pm($urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255));
            for (int i = 0; i < TBL; i++) pulse(4'($urandom_range(0, 15)));
            sb.push_back(model_bit());
            wait_done();
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            set_pm($urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255));
            pulse(4'($urandom_range(0, 15)));
            sb.push_back(model_bit());
            repeat (TBL) step();
        end
        wait_done();
        n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL spaced_overrun: got %0b expected 0", overrun_o); end
    endtask

    task automatic test_shift();
        do_reset();
        set_pm(0, 5, 5, 5);
        fill_const(4'h0);
        sb.push_back(1'b0);
        sb.push_back(1'b0);
        for (int i = TBL - 1; i >= 8; i--) step();
        n_cmp++; if (read_addr_o !== 4'd7) begin n_err++; $display("FAIL shift_at7: addr got %0d expected 7", read_addr_o); end
        pulse(4'h0);
        for (int i = 5; i >= 0; i--) begin
            n_cmp++;
            if (read_addr_o !== 4'(i)) begin
                n_err++;
                $display("FAIL shift_addr: addr got %0d expected %0d", read_addr_o, i);
            end
            step();
        end
        n_cmp++; if (bit_valid_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL shift_end: bit_valid=%0b busy=%0b expected 1/0", bit_valid_o, busy_o);
        end
        step();
        n_cmp++; if (busy_o !== 1'b1 || read_addr_o !== 4'd14) begin
            n_err++;
            $display("FAIL shift_pending: busy=%0b addr=%0d expected 1/14", busy_o, read_addr_o);
        end
        wait_done();
        n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL shift_overrun: got %0b expected 0", overrun_o); end
    endtask

    task automatic test_overrun();
        logic found = 1'b0;
        do_reset();
        set_pm(0, 5, 5, 5);
        fill_const(4'h0);
        sb.push_back(1'b0);
        sb.push_back(1'b0);
        for (int i = 0; i < 20 && !found; i++) begin
            if (read_addr_o == 4'd1 && busy_o) found = 1'b1;
            else step();
        end
        n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL ovr_reach1: addr 1 seen=%0b expected 1", found); end
        pulse(4'h0);
        n_cmp++; if (bit_valid_o !== 1'b1 || overrun_o !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_last: bit_valid=%0b overrun=%0b expected 1/1", bit_valid_o, overrun_o);
        end
        wait_done();
        repeat (5) step();
        n_cmp++; if (overrun_o !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %0b expected 1", overrun_o); end
        do_reset();
        n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %0b expected 0", overrun_o); end
        // Two writes inside one traceback.
        fill_const(4'h0);
        sb.push_back(1'b0);
        sb.push_back(1'b0);
        repeat (3) step();
        pulse(4'h0);
        n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL ovr_one: got %0b expected 0", overrun_o); end
        repeat (3) step();
        pulse(4'h0);
        n_cmp++; if (overrun_o !== 1'b1) begin n_err++; $display("FAIL ovr_two: got %0b expected 1", overrun_o); end
        wait_done();
        repeat (5) step();
        n_cmp++; if (overrun_o !== 1'b1) begin n_err++; $display("FAIL ovr_two_sticky: got %0b expected 1", overrun_o); end
        do_reset();
        n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL ovr_two_clear: got %0b expected 0", overrun_o); end
    endtask

    initial begin
        set_pm(0, 0, 0, 0);
        test_reset();
        test_fill();
        test_paths();
        test_random();
        test_back_to_back();
        test_shift();
        test_overrun();
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
